// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             borrow_out,
    output logic             overflow
`else
    output logic             borrow_out
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bout;

    // Full-subtractor cell on the current LSBs
    assign cell_d    = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    assign cell_bout = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
    // Borrow into the MSB cell differs from the borrow out of it on signed overflow
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state_q == S_RUN && last_bit) begin
                ovf_q <= brw_q ^ cell_bout;
            end
            if (state_q == S_DONE) begin
                overflow <= ovf_q;
            end
        end
    end
`endif

    // Sequencer and datapath; outputs are registered and hold between results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            res_sr_q   <= '0;
            brw_q      <= 1'b0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        brw_q   <= borrow_in;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= {cell_d, res_sr_q[WIDTH-1:1]};
                    brw_q    <= cell_bout;
                    if (last_bit) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done       <= 1'b1;
                    diff       <= res_sr_q;
                    borrow_out <= brw_q;
                    busy       <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors, busy/abort/back-to-back cases.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
        .borrow_out (borrow_out),
        .overflow   (overflow)
`else
        .borrow_out (borrow_out)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] prev_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("borrow_out", 32'(borrow_out), 32'(e.bo));
                chk("latency", cyc - e.cyc, 32'(W + 2));
`ifdef SERIAL_SUB_OVF_EN
                chk("overflow", 32'(overflow), 32'(e.ov));
`endif
            end
        end
    end

    // Drive start for one cycle at a negedge and record the expected result
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input logic [W-1:0] ed, input logic ebo, input logic eov);
        exp_t e;
        a         = ta;
        b         = tb;
        borrow_in = tbin;
        start     = 1'b1;
        e.cyc = cyc;
        e.d   = ed;
        e.bo  = ebo;
        e.ov  = eov;
        sb_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        a         = ~ta;
        b         = ~tb;
        borrow_in = ~tbin;
    endtask

    // Wait (bounded) for done; report busy cycles seen and whether diff moved meanwhile
    task automatic wait_done(input logic [W-1:0] held, output int bc, output logic moved);
        int n;
        n     = 0;
        bc    = 0;
        moved = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bc++;
            if (diff !== held) moved = 1'b1;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input logic [W-1:0] ed, input logic ebo, input logic eov);
        int   bc;
        logic moved;
        issue(ta, tb, tbin, ed, ebo, eov);
        wait_done(prev_d, bc, moved);
        chk("busy_cycles", 32'(bc), 32'(W + 1));
        chk("diff_hold", 32'(moved), 32'(0));
        prev_d = ed;
    endtask

    initial begin
        int   bc;
        logic moved;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset / idle values
        for (int i = 0; i < 5; i++) begin
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_diff", 32'(diff), 32'(0));
            chk("rst_borrow", 32'(borrow_out), 32'(0));
            @(negedge clk);
        end

        // Basic, then busy-ignore case, then back-to-back start in the done cycle
        run(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);
        @(negedge clk);
        a     = 8'h00;
        b     = 8'h55;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(prev_d, bc, moved);
        chk("busy_ignore_hold", 32'(moved), 32'(0));
        prev_d = 8'hFE;
        run(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0);

        // Abort in RUN cycle 4: no done, outputs cleared
        @(negedge clk);
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_diff", 32'(diff), 32'(0));
        chk("abort_borrow", 32'(borrow_out), 32'(0));
        repeat (W + 4) @(negedge clk);
        prev_d = '0;
        run(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);

        // Further directed vectors, issued back-to-back
        run(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run(8'h34, 8'h12, 1'b1, 8'h21, 1'b0, 1'b0);

        repeat (W + 4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
